// File: rtl/tx_frame_controller_pkg.sv
// Shared definitions for the transmit framing path: FSM state codes,
// framing defaults and a counter-width helper.
package tx_defs;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_FETCH   = 3'd2,
    ST_LOAD    = 3'd3,
    ST_SEND    = 3'd4,
    ST_TRAILER = 3'd5,
    ST_GAP     = 3'd6
  } tx_state_e;

  // The input buffer raises its ready flag at this fill level; a frame must fit inside it.
  localparam int         TX_READY_THRESHOLD = 10;
  localparam int         TX_FRAME_BYTES_DEF = TX_READY_THRESHOLD;
  localparam logic [7:0] TX_SYNC_BYTE_DEF   = 8'hA5;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_frame_controller_if.sv
// Bundle between the frame controller, the byte FIFO read port and the
// downstream serializer byte stream.
interface tx_frame_controller_if;

  logic       enable;
  logic       input_ready;
  logic [7:0] fifo_data;
  logic       read_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_done;

  modport master (
    input  enable, input_ready, fifo_data, tx_ready,
    output read_req, tx_data, tx_valid, busy, frame_done
  );

  modport slave (
    output enable, input_ready, fifo_data, tx_ready,
    input  read_req, tx_data, tx_valid, busy, frame_done
  );

endinterface

// File: rtl/tx_frame_controller.sv
// Pulls one frame of payload bytes from the FIFO and streams it to the
// serializer as SYNC, payload, XOR checksum, followed by an idle gap.
module tx_frame_controller
  import tx_defs::*;
#(
  parameter int         FRAME_BYTES = TX_FRAME_BYTES_DEF,
  parameter logic [7:0] SYNC_BYTE   = TX_SYNC_BYTE_DEF,
  parameter int         GAP_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   arst,
  tx_frame_controller_if.master  bus
);

  localparam int             CW       = cnt_w(FRAME_BYTES);
  localparam int             GW       = cnt_w(GAP_CYCLES);
  localparam logic [CW-1:0]  LAST_IDX = CW'(FRAME_BYTES - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_e      r_state;
  tx_state_e      w_next;
  logic [7:0]     r_tx_data;
  logic           r_tx_valid;
  logic           r_frame_done;
  logic [7:0]     r_csum;
  logic [CW-1:0]  r_cnt;
  logic [GW-1:0]  r_gap_cnt;
  logic           w_accept;
  logic           w_last;
  logic           w_read_req;
  logic           w_busy;

  assign w_accept = r_tx_valid & bus.tx_ready;
  assign w_last   = (r_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (bus.enable && bus.input_ready) w_next = ST_HEADER;
      ST_HEADER:  if (w_accept) w_next = ST_FETCH;
      ST_FETCH:   w_next = ST_LOAD;
      ST_LOAD:    w_next = ST_SEND;
      ST_SEND:    if (w_accept) w_next = w_last ? ST_TRAILER : ST_FETCH;
      ST_TRAILER: if (w_accept) w_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:     if (r_gap_cnt == GAP_LAST) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_read_req = (r_state == ST_FETCH);
    w_busy     = (r_state != ST_IDLE);
  end

  // Byte register, checksum and counters; tx_valid is dropped only on an accepting edge.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      r_csum       <= 8'h00;
      r_cnt        <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.enable && bus.input_ready) begin
            r_tx_data  <= SYNC_BYTE;
            r_tx_valid <= 1'b1;
            r_csum     <= 8'h00;
            r_cnt      <= '0;
          end
        end
        ST_HEADER: begin
          if (w_accept) r_tx_valid <= 1'b0;
        end
        ST_LOAD: begin
          r_tx_data  <= bus.fifo_data;
          r_tx_valid <= 1'b1;
          r_csum     <= r_csum ^ bus.fifo_data;
        end
        ST_SEND: begin
          if (w_accept) begin
            if (w_last) begin
              r_tx_data <= r_csum;
            end else begin
              r_cnt      <= r_cnt + 1'b1;
              r_tx_valid <= 1'b0;
            end
          end
        end
        ST_TRAILER: begin
          if (w_accept) begin
            r_frame_done <= 1'b1;
            r_tx_valid   <= 1'b0;
            r_gap_cnt    <= '0;
          end
        end
        ST_GAP: begin
          r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.read_req   = w_read_req;
  assign bus.busy       = w_busy;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_tx_frame_controller.sv
// Bench for tx_frame_controller: cycle table for the opening of a frame,
// directed corner sequences and a randomized run against a frame-level model.
module tb_tx_frame_controller;
  import tx_defs::*;

  localparam int         N1 = 10;
  localparam int         G1 = 2;
  localparam int         N2 = 4;
  localparam int         G2 = 0;
  localparam logic [7:0] SB = 8'hA5;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  tx_frame_controller_if b1();
  tx_frame_controller_if b2();

  tx_frame_controller #(.FRAME_BYTES(N1), .SYNC_BYTE(SB), .GAP_CYCLES(G1)) dut1 (
    .clk(clk), .arst(arst), .bus(b1));
  tx_frame_controller #(.FRAME_BYTES(N2), .SYNC_BYTE(SB), .GAP_CYCLES(G2)) dut2 (
    .clk(clk), .arst(arst), .bus(b2));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: non-showahead, q updates on the edge that samples read_req.
  logic [7:0] fifo1[$];
  logic [7:0] fifo2[$];
  always @(posedge clk) begin
    if (b1.read_req) b1.fifo_data <= (fifo1.size() > 0) ? fifo1.pop_front() : 8'hEE;
    if (b2.read_req) b2.fifo_data <= (fifo2.size() > 0) ? fifo2.pop_front() : 8'hEE;
  end

  // Stream monitors, sampled on the falling edge.
  logic [7:0] got1[$], got2[$];
  int         stamp1[$], stamp2[$], hdr1[$], hdr2[$];
  int         nrd1 = 0, ndn1 = 0, viol1 = 0, pos1 = 0;
  int         nrd2 = 0, ndn2 = 0, pos2 = 0;
  logic       pstall1 = 1'b0;
  logic [7:0] pdata1  = 8'h00;

  always @(negedge clk) begin
    if (!arst) begin
      pos1    <= 0;
      pstall1 <= 1'b0;
    end else begin
      if (pstall1 && !(b1.tx_valid && b1.tx_data == pdata1)) viol1 <= viol1 + 1;
      if (b1.read_req && b1.tx_valid && !b1.tx_ready) viol1 <= viol1 + 1;
      if (b1.read_req) nrd1 <= nrd1 + 1;
      if (b1.frame_done) ndn1 <= ndn1 + 1;
      if (b1.tx_valid && b1.tx_ready) begin
        got1.push_back(b1.tx_data);
        stamp1.push_back(cyc);
        if (pos1 == 0) hdr1.push_back(cyc);
        pos1 <= (pos1 == N1 + 1) ? 0 : pos1 + 1;
      end
      pstall1 <= b1.tx_valid && !b1.tx_ready;
      pdata1  <= b1.tx_data;
    end
  end

  always @(negedge clk) begin
    if (!arst) begin
      pos2 <= 0;
    end else begin
      if (b2.read_req) nrd2 <= nrd2 + 1;
      if (b2.frame_done) ndn2 <= ndn2 + 1;
      if (b2.tx_valid && b2.tx_ready) begin
        got2.push_back(b2.tx_data);
        stamp2.push_back(cyc);
        if (pos2 == 0) hdr2.push_back(cyc);
        pos2 <= (pos2 == N2 + 1) ? 0 : pos2 + 1;
      end
    end
  end

  logic [7:0] exp_q[$];
  logic [7:0] pl[$];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: each frame is SYNC, its payload bytes, then XOR of the payload.
  task automatic add_frames(input logic [7:0] p[$], input int n);
    logic [7:0] x;
    for (int f = 0; f < p.size() / n; f++) begin
      exp_q.push_back(SB);
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(p[f*n+k]);
        x ^= p[f*n+k];
      end
      exp_q.push_back(x);
    end
  endtask

  task automatic chk_stream(input string name, input logic [7:0] g[$]);
    chk({name, "_len"}, g.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < g.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), int'(g[i]), int'(exp_q[i]));
  endtask

  function automatic int cur(input int w);
    case (w)
      0:       return ndn1;
      1:       return hdr1.size();
      2:       return ndn2;
      3:       return hdr2.size();
      default: return 0;
    endcase
  endfunction

  task automatic wait_ev(input int w, input int target, input int lim, input string name);
    int i;
    i = 0;
    while (cur(w) < target && i < lim) begin
      tick();
      i++;
    end
    chk(name, int'(cur(w) >= target), 1);
  endtask

  task automatic wait_byte1(input logic [7:0] d, input int lim);
    int i;
    i = 0;
    while (!(b1.tx_valid && b1.tx_data == d) && i < lim) begin
      tick();
      i++;
    end
    chk($sformatf("wait_byte_%02h", d), int'(b1.tx_valid && b1.tx_data == d), 1);
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, "_read_req"}, int'(b1.read_req), 0);
    chk({tag, "_tx_valid"}, int'(b1.tx_valid), 0);
    chk({tag, "_busy"}, int'(b1.busy), 0);
    chk({tag, "_frame_done"}, int'(b1.frame_done), 0);
    chk({tag, "_tx_data"}, int'(b1.tx_data), 0);
  endtask

  task automatic clr1();
    got1.delete();
    stamp1.delete();
    hdr1.delete();
    exp_q.delete();
    pl.delete();
    fifo1.delete();
  endtask

  typedef struct {
    logic       en, ir, rdy;
    logic       busy, vld, rreq;
    logic [7:0] data;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int rd0, dn0, vi0;
    logic [7:0] b;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h02};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};

    b2.enable = 1'b0; b2.input_ready = 1'b0; b2.tx_ready = 1'b1;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      b1.enable      = ($urandom_range(0, 1) == 1);
      b1.input_ready = ($urandom_range(0, 1) == 1);
      b1.tx_ready    = ($urandom_range(0, 1) == 1);
      tick();
      chk_zero1($sformatf("reset%0d", i));
    end
    chk("reset_busy2", int'(b2.busy), 0);
    arst = 1'b1;
    b1.enable = 1'b1; b1.input_ready = 1'b0; b1.tx_ready = 1'b1;
    rd0 = nrd1;
    repeat (50) tick();
    chk("no_read_without_ready", nrd1 - rd0, 0);
    chk("idle_busy", int'(b1.busy), 0);

    // Opening of the nominal frame, cycle by cycle, then backpressure on 0x03.
    clr1();
    for (int k = 1; k <= 10; k++) begin pl.push_back(8'(k)); fifo1.push_back(8'(k)); end
    rd0 = nrd1; dn0 = ndn1; vi0 = viol1;
    for (int i = 0; i < 9; i++) begin
      b1.enable = tbl[i].en; b1.input_ready = tbl[i].ir; b1.tx_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_busy", i), int'(b1.busy), int'(tbl[i].busy));
      chk($sformatf("vec%0d_tx_valid", i), int'(b1.tx_valid), int'(tbl[i].vld));
      chk($sformatf("vec%0d_read_req", i), int'(b1.read_req), int'(tbl[i].rreq));
      if (tbl[i].vld) chk($sformatf("vec%0d_tx_data", i), int'(b1.tx_data), int'(tbl[i].data));
    end
    wait_byte1(8'h03, 10);
    b1.tx_ready = 1'b0;
    begin
      int r;
      r = nrd1;
      for (int i = 0; i < 5; i++) begin
        tick();
        chk($sformatf("stall%0d_tx_data", i), int'(b1.tx_data), 8'h03);
        chk($sformatf("stall%0d_tx_valid", i), int'(b1.tx_valid), 1);
      end
      chk("stall_no_read", nrd1 - r, 0);
    end
    b1.tx_ready = 1'b1;
    wait_ev(0, dn0 + 1, 100, "nominal_done");
    repeat (5) tick();
    add_frames(pl, N1);
    chk_stream("nominal", got1);
    chk("nominal_reads", nrd1 - rd0, 10);
    chk("nominal_frame_done", ndn1 - dn0, 1);
    chk("nominal_protocol", viol1 - vi0, 0);

    // Back-to-back frames with tx_ready high: HEADER spacing and trailer-to-header gap.
    clr1();
    for (int r = 0; r < 2; r++)
      for (int k = 1; k <= 10; k++) begin pl.push_back(8'(k)); fifo1.push_back(8'(k)); end
    rd0 = nrd1; dn0 = ndn1;
    b1.input_ready = 1'b1;
    wait_ev(1, 2, 100, "b2b_second_header");
    b1.input_ready = 1'b0;
    wait_ev(0, dn0 + 2, 100, "b2b_done");
    repeat (3) tick();
    chk("b2b_hdr_count", hdr1.size(), 2);
    if (hdr1.size() >= 2) chk("b2b_header_spacing", hdr1[1] - hdr1[0], 3 * N1 + 3 + G1);
    if (stamp1.size() > N1 + 2) chk("b2b_trailer_to_header", stamp1[N1+2] - stamp1[N1+1], G1 + 2);
    add_frames(pl, N1);
    chk_stream("b2b", got1);
    chk("b2b_reads", nrd1 - rd0, 20);
    chk("b2b_frame_done", ndn1 - dn0, 2);

    // Enable dropped mid-payload: frame finishes, then stays idle despite input_ready.
    clr1();
    for (int r = 0; r < 2; r++)
      for (int k = 1; k <= 10; k++) fifo1.push_back(8'(k));
    for (int k = 1; k <= 10; k++) pl.push_back(8'(k));
    rd0 = nrd1; dn0 = ndn1;
    b1.enable = 1'b1; b1.input_ready = 1'b1;
    wait_byte1(8'h05, 40);
    b1.enable = 1'b0;
    wait_ev(0, dn0 + 1, 100, "endrop_done");
    repeat (20) tick();
    chk("endrop_busy", int'(b1.busy), 0);
    add_frames(pl, N1);
    chk_stream("endrop", got1);
    chk("endrop_reads", nrd1 - rd0, 10);
    chk("endrop_frame_done", ndn1 - dn0, 1);

    // Asynchronous reset while byte 0x07 is offered; next frame uses only new reads.
    clr1();
    b1.input_ready = 1'b0;
    for (int k = 1; k <= 10; k++) fifo1.push_back(8'(k));
    for (int k = 8; k <= 10; k++) pl.push_back(8'(k));
    for (int k = 0; k < 7; k++) begin
      b = 8'($urandom);
      fifo1.push_back(b);
      pl.push_back(b);
    end
    b1.enable = 1'b1; b1.input_ready = 1'b1;
    wait_byte1(8'h07, 60);
    #2 arst = 1'b0;
    #1 chk_zero1("midreset");
    got1.delete(); stamp1.delete(); hdr1.delete();
    @(posedge clk);
    #1 arst = 1'b1;
    rd0 = nrd1; dn0 = ndn1;
    wait_ev(1, 1, 50, "midreset_header");
    b1.input_ready = 1'b0;
    wait_ev(0, dn0 + 1, 100, "midreset_done");
    repeat (3) tick();
    add_frames(pl, N1);
    chk_stream("midreset", got1);
    chk("midreset_reads", nrd1 - rd0, 10);

    // Randomized run: random backpressure and enable, input_ready follows FIFO fill.
    clr1();
    for (int i = 0; i < 5 * N1; i++) begin
      b = 8'($urandom);
      fifo1.push_back(b);
      pl.push_back(b);
    end
    rd0 = nrd1; dn0 = ndn1; vi0 = viol1;
    for (int i = 0; i < 3000 && ndn1 < dn0 + 5; i++) begin
      b1.tx_ready    = ($urandom_range(0, 99) < 70);
      b1.enable      = ($urandom_range(0, 3) != 0);
      b1.input_ready = (fifo1.size() >= N1);
      tick();
    end
    chk("random_all_done", int'(ndn1 >= dn0 + 5), 1);
    b1.tx_ready = 1'b1; b1.enable = 1'b0; b1.input_ready = 1'b0;
    repeat (5) tick();
    add_frames(pl, N1);
    chk_stream("random", got1);
    chk("random_reads", nrd1 - rd0, 5 * N1);
    chk("random_frame_done", ndn1 - dn0, 5);
    chk("random_protocol", viol1 - vi0, 0);

    // Short frames with no gap and continuous input_ready.
    exp_q.delete(); pl.delete();
    for (int i = 0; i < 3 * N2; i++) begin
      b = 8'($urandom);
      fifo2.push_back(b);
      pl.push_back(b);
    end
    rd0 = nrd2; dn0 = ndn2;
    b2.enable = 1'b1; b2.tx_ready = 1'b1; b2.input_ready = 1'b1;
    wait_ev(3, 3, 200, "gap0_third_header");
    b2.input_ready = 1'b0;
    wait_ev(2, dn0 + 3, 200, "gap0_done");
    repeat (3) tick();
    chk("gap0_hdr_count", hdr2.size(), 3);
    if (hdr2.size() >= 3) begin
      chk("gap0_spacing01", hdr2[1] - hdr2[0], 3 * N2 + 3 + G2);
      chk("gap0_spacing12", hdr2[2] - hdr2[1], 3 * N2 + 3 + G2);
    end
    if (stamp2.size() > N2 + 2) chk("gap0_trailer_to_header", stamp2[N2+2] - stamp2[N2+1], 2);
    add_frames(pl, N2);
    chk_stream("gap0", got2);
    chk("gap0_reads", nrd2 - rd0, 3 * N2);
    chk("gap0_frame_done", ndn2 - dn0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
